cg_vector_address_sequencer: RTL and testbench
==============================================

Name: cg_vector_address_sequencer

Overview:
Parametrised address and iteration sequencer for the conjugate-gradient datapath. It generates read and write addresses for NUM_CH vector memories (P, P_v2, R, X, ...) and the matrix-A stream. Vector depth is derived at run time from `total` and NO_OF_UNITS. It also counts solver iterations and raises halt on convergence (finish_all) or when the iteration limit is reached. It sits between the ALU/vXv pipelines (which issue advance and write strobes) and the vector/matrix memories.

Parameters:
NO_OF_UNITS, 8, parallel lanes; must be a power of two; vector depth = total / NO_OF_UNITS
ADDR_WIDTH, 32, width of every address output
NUM_CH, 4, number of vector memory channels
ITER_WIDTH, 16, width of the iteration counter and the max_iter input

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high; clears all state
start  in  1  pulse; latches total, max_iter and pre_req; leaves IDLE/HALTED
total  in  32  vector length in elements
max_iter  in  ITER_WIDTH  iteration limit; 0 = unlimited
pre_req  in  1  sampled at start; 1 = run PRE phase before RUN
a_adv  in  1  advance the matrix-A read address
pre_done  in  1  end of the preprocessing phase
rd_adv  in  NUM_CH  per-channel read-address advance
wr_en  in  NUM_CH  per-channel write strobe from the result pipelines
finish_alu  in  1  end of one CG iteration
finish_all  in  1  convergence detected
a_rd_addr  out  ADDR_WIDTH  matrix-A read address
rd_addr  out  NUM_CH*ADDR_WIDTH  flattened read addresses; channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
wr_addr  out  NUM_CH*ADDR_WIDTH  flattened write addresses
mem_we  out  NUM_CH  write enables; combinational copy of wr_en, gated to 0 outside RUN
rd_wrap  out  NUM_CH  1-cycle pulse when a read address wraps
wr_wrap  out  NUM_CH  1-cycle pulse when a write address wraps
iter_count  out  ITER_WIDTH  completed iterations
halt  out  1  high in HALTED
busy  out  1  high in PRE, RUN or ITER_END
cfg_err  out  1  sticky; set when start arrives with computed depth 0

Behaviour:
- Reset values: all addresses 0, all pulses 0, iter_count 0, halt 0, busy 0, cfg_err 0, state IDLE.
- Reset takes priority over every other input in any state, including mid-run.
- Depth register: depth = total >> log2(NO_OF_UNITS), latched on an accepted start.
  - If depth == 0: cfg_err is set and the state stays IDLE.
  - cfg_err clears on reset or on the next valid start.
- FSM states: IDLE, PRE, RUN, ITER_END, HALTED.
- IDLE:
  - start with depth != 0 -> PRE if pre_req, else RUN.
  - iter_count and all addresses are cleared on entry to PRE/RUN.
- PRE:
  - a_adv increments a_rd_addr by 1 per cycle; no wrap; wraps mod 2^ADDR_WIDTH only on overflow.
  - pre_done -> RUN on the next cycle.
  - rd_adv and wr_en are ignored; mem_we is 0.
- RUN, per channel c:
  - rd_adv[c]: rd_addr[c] increments. If rd_addr[c] == depth-1, the next value is 0 and rd_wrap[c] pulses in that same update cycle.
  - wr_en[c]: same rule applies to wr_addr[c] and wr_wrap[c].
  - Channels are independent; any subset may advance in the same cycle.
  - Addresses are never >= depth.
- RUN, on finish_alu -> ITER_END:
  - All rd_addr, wr_addr and a_rd_addr clear to 0 next cycle; clearing wins over a same-cycle advance.
  - iter_count increments by 1.
- ITER_END (exactly 1 cycle):
  - If max_iter != 0 and iter_count == max_iter -> HALTED, else -> RUN.
  - Advances and strobes are ignored; mem_we is 0.
- finish_all in PRE or RUN:
  - Next state HALTED; iter_count increments by 1; addresses clear.
  - If asserted in the same cycle as finish_alu, it takes precedence and counts once.
- HALTED:
  - halt = 1; outputs hold; iter_count holds.
  - start restarts as from IDLE, re-latching the configuration.
- start in PRE, RUN or ITER_END is ignored.
- Latency: address outputs are registered and update one cycle after the advance strobe. mem_we has zero latency, so the write data pipe sees wr_addr valid in the same cycle as wr_en (pre-increment value).
- Widths:
  - depth compare is done at ADDR_WIDTH; total is truncated or zero-extended as needed.
  - iter_count saturates at all-ones and does not wrap.

Decomposition:
- Shared package cg_pkg: state enum (IDLE, PRE, RUN, ITER_END, HALTED), the channel index constants CH_P = 0, CH_PV2 = 1, CH_R = 2, CH_X = 3, and the NO_OF_UNITS default.
- One natural sub-module, cg_wrap_counter: ADDR_WIDTH counter with inc, clr, depth and wrap outputs. Instantiate 2*NUM_CH copies in a generate loop.
- The A counter and the FSM remain in the top level.

Test Plan:
- total=32, no pre_req, start; then 4 consecutive rd_adv[2] -> rd_addr[2] goes 1,2,3,0; rd_wrap[2] pulses on the 4th update; other channels stay at 0.
- total=64, max_iter=3; each iteration issues 8 wr_en[3] plus finish_alu -> wr_wrap[3] once per iteration; iter_count 1,2,3; halt rises 2 cycles after the 3rd finish_alu.
- pre_req=1, 5 a_adv, then pre_done -> a_rd_addr=5; state RUN; mem_we stays 0 during PRE even with wr_en=1.
- In RUN, finish_alu, finish_all and rd_adv[0] in the same cycle -> HALTED; iter_count incremented once; rd_addr[0]=0.
- total=4 (depth 0), start -> cfg_err=1, busy=0; then total=16, start -> cfg_err=0, RUN.
- Mid-RUN with addresses at 3, assert reset for 1 cycle -> every output at its reset value the next cycle; a start pulse during RUN has no effect.

Source files
------------

// File: rtl/cg_vector_address_sequencer_pkg.sv
// Shared types and constants for the conjugate-gradient address sequencer.
package cg_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE      = 3'd1,
    RUN      = 3'd2,
    ITER_END = 3'd3,
    HALTED   = 3'd4
  } cg_state_e;

  localparam int unsigned CH_P   = 0;
  localparam int unsigned CH_PV2 = 1;
  localparam int unsigned CH_R   = 2;
  localparam int unsigned CH_X   = 3;

  localparam int unsigned NO_OF_UNITS_DEF = 8;

endpackage

// File: rtl/cg_vector_address_sequencer_wrap_counter.sv
// Address counter that wraps to zero after depth-1 and pulses wrap on that update.
module cg_wrap_counter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] depth,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  wrap
);

  logic at_last_c;

  assign at_last_c = (count == depth - ADDR_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (inc) begin
        if (at_last_c) begin
          count <= '0;
          wrap  <= 1'b1;
        end else begin
          count <= count + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cg_vector_address_sequencer.sv
// Address and iteration sequencer for the CG datapath: vector/matrix address
// generation, iteration counting and halt on convergence or iteration limit.
module cg_vector_address_sequencer
  import cg_pkg::*;
#(
  parameter int unsigned NO_OF_UNITS = NO_OF_UNITS_DEF,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ITER_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [31:0]                  total,
  input  logic [ITER_WIDTH-1:0]        max_iter,
  input  logic                         pre_req,
  input  logic                         a_adv,
  input  logic                         pre_done,
  input  logic [NUM_CH-1:0]            rd_adv,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic                         finish_alu,
  input  logic                         finish_all,
  output logic [ADDR_WIDTH-1:0]        a_rd_addr,
  output logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_CH-1:0]            mem_we,
  output logic [NUM_CH-1:0]            rd_wrap,
  output logic [NUM_CH-1:0]            wr_wrap,
  output logic [ITER_WIDTH-1:0]        iter_count,
  output logic                         halt,
  output logic                         busy,
  output logic                         cfg_err
);

  localparam int unsigned UNIT_SHIFT = $clog2(NO_OF_UNITS);

  cg_state_e             state, state_next;
  logic [ADDR_WIDTH-1:0] depth;
  logic [ADDR_WIDTH-1:0] depth_in_c;
  logic [ITER_WIDTH-1:0] max_iter_q;
  logic                  clr_c;
  logic                  iter_inc_c;
  logic                  accept_c;
  logic                  cfg_set_c;
  logic                  run_c;
  logic                  a_inc_c;

  assign depth_in_c = ADDR_WIDTH'(total >> UNIT_SHIFT);
  assign run_c      = (state == RUN);
  assign a_inc_c    = a_adv && (state == PRE || state == RUN);
  assign mem_we     = run_c ? wr_en : '0;

  // Next-state and control strobes; clearing takes priority over advances.
  always_comb begin
    state_next = state;
    clr_c      = 1'b0;
    iter_inc_c = 1'b0;
    accept_c   = 1'b0;
    cfg_set_c  = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (start) begin
          if (depth_in_c != '0) begin
            accept_c   = 1'b1;
            clr_c      = 1'b1;
            state_next = pre_req ? PRE : RUN;
          end else begin
            cfg_set_c = 1'b1;
          end
        end
      end
      PRE: begin
        if (finish_all) begin
          state_next = HALTED;
          clr_c      = 1'b1;
          iter_inc_c = 1'b1;
        end else if (pre_done) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (finish_all) begin
          state_next = HALTED;
          clr_c      = 1'b1;
          iter_inc_c = 1'b1;
        end else if (finish_alu) begin
          state_next = ITER_END;
          clr_c      = 1'b1;
          iter_inc_c = 1'b1;
        end
      end
      ITER_END: begin
        if (max_iter_q != '0 && iter_count == max_iter_q) state_next = HALTED;
        else                                              state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      depth      <= '0;
      max_iter_q <= '0;
      iter_count <= '0;
      cfg_err    <= 1'b0;
      halt       <= 1'b0;
      busy       <= 1'b0;
      a_rd_addr  <= '0;
    end else begin
      state <= state_next;
      halt  <= (state_next == HALTED);
      busy  <= (state_next == PRE || state_next == RUN || state_next == ITER_END);
      if (accept_c) begin
        depth      <= depth_in_c;
        max_iter_q <= max_iter;
        cfg_err    <= 1'b0;
      end else if (cfg_set_c) begin
        cfg_err <= 1'b1;
      end
      // iter_count saturates rather than wrapping
      if (accept_c)                          iter_count <= '0;
      else if (iter_inc_c && iter_count != '1) iter_count <= iter_count + ITER_WIDTH'(1);
      if (clr_c)        a_rd_addr <= '0;
      else if (a_inc_c) a_rd_addr <= a_rd_addr + ADDR_WIDTH'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt;

    cg_wrap_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd (
      .clk   (clk),
      .reset (reset),
      .inc   (rd_adv[c] & run_c),
      .clr   (clr_c),
      .depth (depth),
      .count (rd_cnt),
      .wrap  (rd_wrap[c])
    );

    cg_wrap_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_en[c] & run_c),
      .clr   (clr_c),
      .depth (depth),
      .count (wr_cnt),
      .wrap  (wr_wrap[c])
    );

    assign rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = rd_cnt;
    assign wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = wr_cnt;
  end

endmodule

// File: tb/tb_cg_vector_address_sequencer.sv
// Directed self-checking bench for cg_vector_address_sequencer.
module tb_cg_vector_address_sequencer;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  total;
  logic [15:0]  max_iter;
  logic         pre_req;
  logic         a_adv;
  logic         pre_done;
  logic [3:0]   rd_adv;
  logic [3:0]   wr_en;
  logic         finish_alu;
  logic         finish_all;
  logic [31:0]  a_rd_addr;
  logic [127:0] rd_addr;
  logic [127:0] wr_addr;
  logic [3:0]   mem_we;
  logic [3:0]   rd_wrap;
  logic [3:0]   wr_wrap;
  logic [15:0]  iter_count;
  logic         halt;
  logic         busy;
  logic         cfg_err;

  int total_cnt = 0;
  int bad_cnt   = 0;

  cg_vector_address_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .total      (total),
    .max_iter   (max_iter),
    .pre_req    (pre_req),
    .a_adv      (a_adv),
    .pre_done   (pre_done),
    .rd_adv     (rd_adv),
    .wr_en      (wr_en),
    .finish_alu (finish_alu),
    .finish_all (finish_all),
    .a_rd_addr  (a_rd_addr),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .mem_we     (mem_we),
    .rd_wrap    (rd_wrap),
    .wr_wrap    (wr_wrap),
    .iter_count (iter_count),
    .halt       (halt),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch(input logic [127:0] v, input int c);
    return v[c*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; a_adv = 0; pre_done = 0; rd_adv = '0; wr_en = '0;
    finish_alu = 0; finish_all = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic do_start(input logic [31:0] t, input logic [15:0] mi, input logic pr);
    total = t; max_iter = mi; pre_req = pr; start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    int wraps;
    reset = 1; total = '0; max_iter = '0; pre_req = 0;
    idle_inputs();
    tick();
    tick();
    reset = 0;
    check("rst_a", a_rd_addr, 0);
    check("rst_rd", rd_addr[63:0], 0);
    check("rst_wr", wr_addr[63:0], 0);
    check("rst_flags", {halt, busy, cfg_err, rd_wrap, wr_wrap}, 0);
    check("rst_iter", iter_count, 0);

    // depth 4: channel 2 reads 1,2,3,0 with a wrap on the last
    do_start(32, 0, 0);
    check("t1_busy", busy, 1);
    rd_adv = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t1_rd2_%0d", i), ch(rd_addr, 2), (i == 4) ? 0 : i);
      check($sformatf("t1_wrap_%0d", i), rd_wrap, (i == 4) ? 4'b0100 : 4'b0000);
    end
    rd_adv = '0;
    tick();
    check("t1_wrap_off", rd_wrap, 0);
    check("t1_others", {ch(rd_addr, 0), ch(rd_addr, 1), ch(rd_addr, 3)}, 0);

    // depth 8, max_iter 3
    do_reset();
    do_start(64, 3, 0);
    for (int it = 1; it <= 3; it++) begin
      wraps = 0;
      wr_en = 4'b1000;
      #1;
      check($sformatf("t2_we_%0d", it), mem_we, 4'b1000);
      for (int k = 0; k < 8; k++) begin
        tick();
        if (wr_wrap[3]) wraps++;
      end
      wr_en = '0;
      check($sformatf("t2_wraps_%0d", it), wraps, 1);
      check($sformatf("t2_wr3_%0d", it), ch(wr_addr, 3), 0);
      finish_alu = 1;
      tick();
      finish_alu = 0;
      check($sformatf("t2_iter_%0d", it), iter_count, it);
      check($sformatf("t2_iehalt_%0d", it), {halt, busy}, 2'b01);
      tick();
      check($sformatf("t2_halt_%0d", it), {halt, busy}, (it == 3) ? 2'b10 : 2'b01);
    end

    // PRE phase: A address advances, write enables gated
    do_reset();
    do_start(32, 0, 1);
    a_adv = 1; wr_en = 4'hF;
    #1;
    check("t3_we_pre", mem_we, 0);
    for (int k = 0; k < 5; k++) tick();
    a_adv = 0; wr_en = '0; pre_done = 1;
    tick();
    pre_done = 0;
    check("t3_a", a_rd_addr, 5);
    check("t3_wr_pre", wr_addr[63:0], 0);
    wr_en = 4'b0001;
    #1;
    check("t3_we_run", mem_we, 4'b0001);
    tick();
    wr_en = '0;
    check("t3_wr0", ch(wr_addr, 0), 1);

    // finish_alu + finish_all + rd_adv together
    rd_adv = 4'b0001;
    tick();
    check("t4_rd0_pre", ch(rd_addr, 0), 1);
    finish_alu = 1; finish_all = 1;
    tick();
    idle_inputs();
    check("t4_halt", halt, 1);
    check("t4_iter", iter_count, 1);
    check("t4_rd0", ch(rd_addr, 0), 0);
    check("t4_a", a_rd_addr, 0);
    tick();
    check("t4_hold", {halt, iter_count}, {1'b1, 16'd1});

    // zero depth then valid restart
    do_start(4, 0, 0);
    check("t5_err", {cfg_err, busy}, 2'b10);
    do_start(16, 0, 0);
    check("t5_ok", {cfg_err, busy, halt}, 3'b010);
    check("t5_iter", iter_count, 0);

    // reset mid-run; start during RUN ignored
    do_reset();
    do_start(64, 0, 0);
    rd_adv = 4'hF; wr_en = 4'hF; a_adv = 1;
    for (int k = 0; k < 3; k++) tick();
    idle_inputs();
    check("t6_rd1", ch(rd_addr, 1), 3);
    start = 1; total = 8;
    tick();
    start = 0;
    check("t6_ign_rd", ch(rd_addr, 1), 3);
    check("t6_ign_a", {a_rd_addr, busy, cfg_err}, {32'd3, 1'b1, 1'b0});
    reset = 1;
    tick();
    reset = 0;
    check("t6_rst_a", a_rd_addr, 0);
    check("t6_rst_rd", {rd_addr[127:96], rd_addr[31:0]}, 0);
    check("t6_rst_wr", {wr_addr[127:96], wr_addr[31:0]}, 0);
    check("t6_rst_flags", {halt, busy, cfg_err, rd_wrap, wr_wrap, mem_we}, 0);
    check("t6_rst_iter", iter_count, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
